// File: rtl/hilo_div_if.sv
// hilo_div_if: request/response bundle between the execute stage and the
// HI/LO divider. The execute side (master) supplies operands and the
// start/annul controls. The divider (slave) returns the result, ready and
// the stall request.
interface hilo_div_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/hilo_div.sv
// hilo_div: multi-cycle 32-bit restoring divider for DIV/DIVU.
// The result is {remainder, quotient}, which is written to {hi, lo}.
// Each operation takes one restoring step per cycle for 32 cycles on
// operand magnitudes. Sign correction is applied when the result is
// registered.
//
// Optional feature: define HILO_DIV_ZERO_CHECK_EN to short-circuit a zero
// divisor through a BYZERO state. That path returns an all-zero result two
// edges after capture. Without the macro, a zero divisor runs the full
// iteration.
module hilo_div (
  input  logic        clk,
  input  logic        rst,
  hilo_div_if.slave   bus
);

`ifdef HILO_DIV_ZERO_CHECK_EN
  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_ON     = 2'd1,
    S_END    = 2'd2,
    S_BYZERO = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_FREE = 2'd0,
    S_ON   = 2'd1,
    S_END  = 2'd2
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;       // {partial remainder, dividend/quotient, lsb}
  logic [31:0] dvs_q, dvs_d;         // divisor magnitude
  logic        quo_neg_q, quo_neg_d; // operand signs differed (signed only)
  logic        rem_neg_q, rem_neg_d; // dividend was negative (signed only)
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] op1_abs, op2_abs;
  logic [32:0] diff;
  logic [31:0] quo_raw, rem_raw, quo_fix, rem_fix;

  // Operand magnitudes, trial subtraction and sign-corrected results
  assign op1_abs = (bus.signed_div_i && bus.opdata1_i[31]) ? -bus.opdata1_i : bus.opdata1_i;
  assign op2_abs = (bus.signed_div_i && bus.opdata2_i[31]) ? -bus.opdata2_i : bus.opdata2_i;
  assign diff    = work_q[64:32] - {1'b0, dvs_q};
  assign quo_raw = work_q[31:0];
  assign rem_raw = work_q[64:33];
  assign quo_fix = quo_neg_q ? -quo_raw : quo_raw;
  assign rem_fix = rem_neg_q ? -rem_raw : rem_raw;

  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  assign bus.stallreq_o = bus.start_i & ~ready_q & ~bus.annul_i;

  // Next-state logic: capture, iterate, present the result, release
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves one unassigned (which would infer a latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    dvs_d     = dvs_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      S_FREE: begin
        result_d = 64'h0;
        ready_d  = 1'b0;
        if (bus.start_i && !bus.annul_i) begin
          quo_neg_d = bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
          rem_neg_d = bus.signed_div_i & bus.opdata1_i[31];
          dvs_d     = op2_abs;
          work_d    = {32'h0, op1_abs, 1'b0};
          cnt_d     = 6'd0;
`ifdef HILO_DIV_ZERO_CHECK_EN
          state_d   = (bus.opdata2_i == 32'h0) ? S_BYZERO : S_ON;
`else
          state_d   = S_ON;
`endif
        end
      end

`ifdef HILO_DIV_ZERO_CHECK_EN
      S_BYZERO: begin
        // A zeroed work register with no sign correction yields an all-zero result.
        work_d    = 65'h0;
        quo_neg_d = 1'b0;
        rem_neg_d = 1'b0;
        state_d   = bus.annul_i ? S_FREE : S_END;
      end
`endif

      S_ON: begin
        if (bus.annul_i) begin
          state_d = S_FREE;
        end else begin
          if (!diff[32]) work_d = {diff[31:0], work_q[31:0], 1'b1};
          else           work_d = {work_q[63:0], 1'b0};
          cnt_d = cnt_q + 6'd1;
          // cnt_q == 31 means this edge performs the 32nd step.
          if (cnt_q == 6'd31) state_d = S_END;
        end
      end

      S_END: begin
        if (bus.annul_i || !bus.start_i) begin
          state_d  = S_FREE;
          result_d = 64'h0;
          ready_d  = 1'b0;
        end else begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
        end
      end

      default: begin
        state_d  = S_FREE;
        result_d = 64'h0;
        ready_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= S_FREE;
      cnt_q     <= 6'd0;
      work_q    <= 65'h0;
      dvs_q     <= 32'h0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= 64'h0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      dvs_q     <= dvs_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

endmodule

// File: tb/tb_hilo_div.sv
// tb_hilo_div: self-checking bench for hilo_div.
// It applies a directed vector table, hand-written annul/reset/END
// sequences, and randomized divides. Results are compared against an
// arithmetic reference model.
module tb_hilo_div;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hilo_div_if bus ();

  hilo_div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef HILO_DIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain integer division following the DIV/DIVU rules.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [31:0] q, r;
    if (b == 32'h0) begin
      if (ZCHK) return 64'h0;
      q = (sgn && a[31]) ? 32'h1 : 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[31:0];
      r  = sr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic int ref_lat(input logic [31:0] b);
    return (ZCHK && b == 32'h0) ? 2 : 33;
  endfunction

  // Waits for the capture edge, then counts edges until ready (bounded).
  task automatic wait_ready(input bit scramble, output int lat, output int stall_cnt);
    lat = 0;
    stall_cnt = 0;
    @(posedge clk); #1;
    while (bus.ready_o !== 1'b1 && lat < 60) begin
      if (bus.stallreq_o === 1'b1) stall_cnt++;
      if (scramble) begin
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Drops start in END and expects outputs cleared on the next edge.
  task automatic release_div(input string name);
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    check({name, "_rel_ready"}, 64'(bus.ready_o), 64'h0);
    check({name, "_rel_result"}, bus.result_o, 64'h0);
  endtask

  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat,
                         input bit scramble);
    int lat, stall_cnt;
    @(negedge clk);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    #1 check({name, "_stall_req"}, 64'(bus.stallreq_o), 64'h1);
    wait_ready(scramble, lat, stall_cnt);
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_lat));
    check({name, "_result"}, bus.result_o, exp);
    check({name, "_stall_at_ready"}, 64'(bus.stallreq_o), 64'h0);
    release_div(name);
  endtask

  vec_t vecs[7];

  initial begin
    int lat, stall_cnt;
    checks = 0;
    errors = 0;

    vecs[0] = '{"u100_7",    1'b0, 32'd100,      32'd7,        {32'd2, 32'd14},                0};
    vecs[1] = '{"s_m7_2",    1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD},   0};
    vecs[2] = '{"s_7_m2",    1'b1, 32'd7,        32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD},          0};
    vecs[3] = '{"s_min_m1",  1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000},          0};
    vecs[4] = '{"u_div0",    1'b0, 32'h1234,     32'd0,
                ZCHK ? 64'h0 : {32'h1234, 32'hFFFFFFFF}, 0};
    vecs[5] = '{"u_max_1",   1'b0, 32'hFFFFFFFF, 32'd1,        {32'd0, 32'hFFFFFFFF},          0};
    vecs[6] = '{"s_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14},         0};
    foreach (vecs[i]) vecs[i].lat = ref_lat(vecs[i].b);

    // Reset state
    rst = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'h0;
    bus.opdata2_i    = 32'h0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(bus.ready_o), 64'h0);
    check("reset_result", bus.result_o, 64'h0);
    check("reset_stall", 64'(bus.stallreq_o), 64'h0);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.annul_i = 1'b1;
    #1 check("stall_masked_by_annul", 64'(bus.stallreq_o), 64'h0);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    rst = 1'b0;

    // Directed vector table; back-to-back with one FREE cycle between
    for (int i = 0; i < 7; i++)
      run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b0);

    // Annul mid-divide, then a fresh request with operands scrambled after capture
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    @(posedge clk);                      // E0
    repeat (10) @(posedge clk);          // E10
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk); #1;                  // E11
    check("annul_ready", 64'(bus.ready_o), 64'h0);
    check("annul_result", bus.result_o, 64'h0);
    @(negedge clk);
    bus.annul_i      = 1'b0;
    bus.signed_div_i = 1'b1;
    bus.opdata1_i    = 32'hFFFFFC18;     // -1000
    bus.opdata2_i    = 32'd7;
    wait_ready(1'b1, lat, stall_cnt);
    check("after_annul_latency", 64'(lat), 64'd33);
    check("after_annul_result", bus.result_o, {32'hFFFFFFFA, 32'hFFFFFF72});
    release_div("after_annul");

    // Annul while in END clears the outputs on the next edge
    run_div("pre_end_annul", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33, 1'b0);
    @(negedge clk);
    bus.opdata1_i = 32'd81;
    bus.opdata2_i = 32'd9;
    bus.start_i   = 1'b1;
    wait_ready(1'b0, lat, stall_cnt);
    check("end_annul_pre_ready", 64'(bus.ready_o), 64'h1);
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk); #1;
    check("end_annul_ready", 64'(bus.ready_o), 64'h0);
    check("end_annul_result", bus.result_o, 64'h0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;

    // Reset at E20 mid-divide, then a fresh request right after release
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd999;
    bus.opdata2_i    = 32'd10;
    bus.start_i      = 1'b1;
    @(posedge clk);                      // E0
    repeat (19) @(posedge clk);          // E19
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;                  // E20
    check("rst_mid_ready", 64'(bus.ready_o), 64'h0);
    check("rst_mid_result", bus.result_o, 64'h0);
    check("rst_mid_stall", 64'(bus.stallreq_o), 64'h1);
    @(negedge clk);
    rst = 1'b0;
    bus.opdata1_i = 32'd77;
    bus.opdata2_i = 32'd8;
    wait_ready(1'b0, lat, stall_cnt);
    check("after_rst_latency", 64'(lat), 64'd33);
    check("after_rst_result", bus.result_o, {32'd5, 32'd9});
    release_div("after_rst");

    // Randomized divides against the reference model
    for (int n = 0; n < 40; n++) begin
      logic        sgn;
      logic [31:0] a, b;
      sgn = 1'($urandom);
      a   = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'($urandom_range(1, 15));
        1:       b = 32'h0;
        2:       b = -32'($urandom_range(1, 300));
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      run_div($sformatf("rand%0d", n), sgn, a, b, ref_div(sgn, a, b), ref_lat(b), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
